aes_round_ctrl: RTL

Sequencing controller for the AES encryption datapath. On a start request it decodes the key-size select into Nk/Nr, runs the key-expansion word schedule, then issues per-round control strobes (initial AddRoundKey, Nr-1 full rounds, final round without MixColumns). It signals completion with a held done/ack handshake. It sits between the host-side command interface and the key-expansion and state-round datapath units, which it drives with enables and indices only; it carries no data.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/typeAES.sv | 16 +
 rtl/aes_round_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared encodings, state enum and key-size constants for the AES round controller
package aes_pkg;

    localparam logic [1:0] AES_128     = 2'b00;
    localparam logic [1:0] AES_192     = 2'b01;
    localparam logic [1:0] AES_256     = 2'b10;
    localparam logic [1:0] AES_INVALID = 2'b11;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_INIT,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    // Key length in 32-bit words; the invalid code falls back to AES-128 values
    function automatic logic [3:0] nk_of(input logic [1:0] sel);
        case (sel)
            AES_192: return NK_192;
            AES_256: return NK_256;
            default: return NK_128;
        endcase
    endfunction

    // Number of rounds for a key-size select
    function automatic logic [3:0] nr_of(input logic [1:0] sel);
        case (sel)
            AES_192: return NR_192;
            AES_256: return NR_256;
            default: return NR_128;
        endcase
    endfunction

    // Multiply by x in GF(2^8): next round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/typeAES.sv
// rtl/typeAES.sv - decodes a key-size select into Nk (key words) and Nr (rounds)
module typeAES
    import aes_pkg::*;
(
    input  logic [1:0] i_sel,
    output logic [3:0] o_nk,
    output logic [3:0] o_nr
);

    // Pure table lookup on the select
    always_comb begin
        o_nk = nk_of(i_sel);
        o_nr = nr_of(i_sel);
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - sequences key expansion and round strobes for the AES datapath
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int KIDX_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        sel_i,
    input  logic              start_i,
    input  logic              ack_i,
    output logic              ready_o,
    output logic              err_o,
    output logic              kexp_en_o,
    output logic [KIDX_W-1:0] kexp_idx_o,
    output logic              kexp_rot_o,
    output logic              kexp_sub_o,
    output logic [7:0]        rcon_o,
    output logic              load_o,
    output logic [3:0]        round_o,
    output logic              sub_shift_en_o,
    output logic              mix_en_o,
    output logic              ark_en_o,
    output logic              done_o
);

    state_t            r_state;
    logic [1:0]        r_sel;
    logic [KIDX_W-1:0] r_i;
    logic [2:0]        r_j;
    logic [7:0]        r_rcon;
    logic [3:0]        r_round;
    logic              r_err;

    logic [3:0]        w_nk;
    logic [3:0]        w_nr;
    logic [KIDX_W-1:0] w_last_idx;
    logic              w_j_last;
    logic              w_in_keyexp;
    logic              w_in_rounds;

    typeAES u_type (
        .i_sel (r_sel),
        .o_nk  (w_nk),
        .o_nr  (w_nr)
    );

    // Last key word index is 4*(Nr+1)-1; j wraps at Nk-1 so i mod Nk needs no divider
    assign w_last_idx  = ((KIDX_W'(w_nr) + KIDX_W'(1)) << 2) - KIDX_W'(1);
    assign w_j_last    = (r_j == 3'(w_nk - 4'd1));
    assign w_in_keyexp = (r_state == ST_KEYEXP);
    assign w_in_rounds = (r_state == ST_INIT) || (r_state == ST_ROUND) || (r_state == ST_FINAL);

    // Controller FSM with its word, rcon and round counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_sel   <= AES_128;
            r_i     <= '0;
            r_j     <= '0;
            r_rcon  <= '0;
            r_round <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (sel_i == AES_INVALID) begin
                            r_err <= 1'b1;
                        end else begin
                            r_sel   <= sel_i;
                            r_i     <= KIDX_W'(nk_of(sel_i));
                            r_j     <= '0;
                            r_rcon  <= 8'h01;
                            r_state <= ST_KEYEXP;
                        end
                    end
                end
                ST_KEYEXP: begin
                    r_i <= r_i + KIDX_W'(1);
                    r_j <= w_j_last ? 3'd0 : r_j + 3'd1;
                    if (r_j == 3'd0) begin
                        r_rcon <= xtime(r_rcon);
                    end
                    if (r_i == w_last_idx) begin
                        r_round <= 4'd0;
                        r_state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    r_round <= 4'd1;
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (r_round == w_nr - 4'd1) begin
                        r_round <= w_nr;
                        r_state <= ST_FINAL;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                ST_FINAL: begin
                    r_round <= 4'd0;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (ack_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready_o        = (r_state == ST_IDLE);
    assign err_o          = r_err;
    assign kexp_en_o      = w_in_keyexp;
    assign kexp_idx_o     = w_in_keyexp ? r_i : '0;
    assign kexp_rot_o     = w_in_keyexp && (r_j == 3'd0);
    assign kexp_sub_o     = w_in_keyexp && (w_nk == NK_256) && (r_j == 3'd4);
    assign rcon_o         = w_in_keyexp ? r_rcon : 8'h00;
    assign load_o         = (r_state == ST_INIT);
    assign round_o        = w_in_rounds ? r_round : 4'd0;
    assign sub_shift_en_o = (r_state == ST_ROUND) || (r_state == ST_FINAL);
    assign mix_en_o       = (r_state == ST_ROUND);
    assign ark_en_o       = w_in_rounds;
    assign done_o         = (r_state == ST_DONE);

endmodule
